kitchen_link_responder: RTL

KITCHEN_LINK_RESPONDER -- requirements
Module: kitchen_link_responder

---
 rtl/kitchen_link_responder_if.sv | 26 ++
 rtl/kitchen_link_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/kitchen_link_responder_if.sv
// Line-side and status bundle for kitchen_link_responder.
// The master drives rx; the slave (the responder) drives everything else.
interface kitchen_link_responder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx;
  logic          tx;
  logic          rx_valid;
  logic [7:0]    rx_bits;
  logic          frame_err;
  logic          overflow;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output rx,
    input  tx, rx_valid, rx_bits, frame_err, overflow, tx_busy, fifo_count
  );

  modport slave (
    input  rx,
    output tx, rx_valid, rx_bits, frame_err, overflow, tx_busy, fifo_count
  );
endinterface

// File: rtl/kitchen_link_responder.sv
// 8N1 responder: receives bytes on rx and answers non-zero-type bytes with {byte[7:2],2'b01} on tx.
// Rx result one cycle after the stop-bit sample; acks queue in a FIFO_DEPTH (power of two, >=2) FIFO, dropped when full.
module kitchen_link_responder #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  kitchen_link_responder_if.slave link
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]    COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  // Receive path
  logic             sync1_q, sync2_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_bits_q, rx_bits_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             push;
  logic [7:0]       push_dat;

  // Ack queue
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, pop, push_ok;

  // Transmit path
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick;
  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic             tx_q, tx_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_bits_d   = rx_bits_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_dat    = {rx_shift_q[7:2], 2'b01};
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_state_d = R_START;
      end
      R_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CNT_HALF) begin
          // Mid-start recheck; a high level here was a glitch, not a frame.
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = sync2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (sync2_q) begin
            rx_bits_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            push       = (rx_shift_q[1:0] != 2'b00);
            rx_state_d = R_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = R_WAIT_HIGH;
          end
        end
      end
      R_WAIT_HIGH: begin
        if (sync2_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  assign tick = (div_q == CNT_LAST);

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    if (tick) begin
      case (tx_state_q)
        T_IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_mem_q[rd_ptr_q];
            tx_d       = 1'b0;
            tx_state_d = T_START;
          end
        end
        T_START: begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = '0;
          tx_state_d = T_DATA;
        end
        T_DATA: begin
          if (tx_idx_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = tx_idx_q + 1'b1;
          end
        end
        T_STOP: begin
          tx_d       = 1'b1;
          tx_state_d = T_IDLE;
        end
        default: tx_state_d = T_IDLE;
      endcase
    end
  end

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  always_comb begin
    push_ok    = push && (!full || pop);
    overflow_d = push && full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_bits_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      div_q       <= '0;
      tx_state_q  <= T_IDLE;
      tx_shift_q  <= '0;
      tx_idx_q    <= '0;
      tx_q        <= 1'b1;
    end else begin
      sync1_q     <= link.rx;
      sync2_q     <= sync1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_bits_q   <= rx_bits_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      div_q       <= div_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_idx_q    <= tx_idx_d;
      tx_q        <= tx_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) fifo_mem_q[wr_ptr_q] <= push_dat;
  end

  assign link.tx         = tx_q;
  assign link.rx_valid   = rx_valid_q;
  assign link.rx_bits    = rx_bits_q;
  assign link.frame_err  = frame_err_q;
  assign link.overflow   = overflow_q;
  assign link.tx_busy    = (tx_state_q != T_IDLE);
  assign link.fifo_count = count_q;
endmodule
